// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operation/result handshake bundle for the pipelined execute ALU.
//   Request side : in_valid, in_ready, op_a, op_b, imm, alu_sel, alu_control
//   Response side: out_valid, out_ready, alu_result, zero_flag, bt, busy
// master = upstream/downstream driver (decode stage, writeback stage)
// slave  = the ALU itself
interface alu_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] imm;
    logic [1:0]      alu_sel;
    logic [3:0]      alu_control;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_result;
    logic            zero_flag;
    logic            bt;
    logic            busy;

    modport master (
        output in_valid, op_a, op_b, imm, alu_sel, alu_control, out_ready,
        input  in_ready, out_valid, alu_result, zero_flag, bt, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, imm, alu_sel, alu_control, out_ready,
        output in_ready, out_valid, alu_result, zero_flag, bt, busy
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked execute-stage ALU.
//   Single-cycle ops (ALU, immediate, shifts, set-less-than, branch compare)
//   register their result on the accepting edge. MUL runs on an iterative
//   shift-add engine (one multiplier bit per cycle) when MUL_EN=1.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - alu_pipe_if slave: valid/ready request with operands and op
//           select, valid/ready response with alu_result, zero_flag, bt,
//           plus busy while the multiplier is running.
module alu_pipe #(
    parameter int XLEN   = 32,
    parameter int MUL_EN = 1
) (
    input  logic       clk,
    input  logic       reset,
    alu_pipe_if.slave  bus
);

    localparam int SHW = $clog2(XLEN);
    // Multiplier walks XLEN bits, then spends one more edge loading the result
    localparam logic [SHW:0] MUL_LAST = XLEN[SHW:0];
    localparam logic [SHW:0] CNT_ONE  = {{SHW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        OUT     = 2'd2
    } state_t;

    // Returns {bt, result} for every op that completes in a single cycle.
    function automatic logic [XLEN:0] alu_eval(
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b_reg,
        input logic [XLEN-1:0] imm_v,
        input logic [1:0]      sel,
        input logic [3:0]      ctl
    );
        logic [XLEN-1:0]        b;
        logic [XLEN-1:0]        r;
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        logic [SHW-1:0]         sh;
        logic                   t;
        b  = (sel == 2'b01) ? imm_v : b_reg;
        sa = a;
        sb = b;
        sh = b[SHW-1:0];
        r  = '0;
        t  = 1'b0;
        case (sel)
            2'b00, 2'b01: begin
                case (ctl)
                    4'd0:    r = a + b;
                    4'd1:    r = a - b;
                    4'd2:    r = a | b;
                    4'd3:    r = a & b;
                    4'd4:    r = a ^ b;
                    4'd5:    r = a << sh;
                    4'd6:    r = a >> sh;
                    4'd7:    r = $unsigned(sa >>> sh);
                    4'd8:    r = {{(XLEN-1){1'b0}}, (sa < sb)};
                    4'd9:    r = {{(XLEN-1){1'b0}}, (a < b)};
                    // MUL in the immediate class, MUL with the engine
                    // disabled, and unused codes all yield zero
                    default: r = '0;
                endcase
            end
            2'b10: begin
                case (ctl)
                    4'd0:    t = (a == b);
                    4'd1:    t = (a != b);
                    4'd2:    t = (sa < sb);
                    4'd3:    t = (sa >= sb);
                    4'd4:    t = (a < b);
                    4'd5:    t = (a >= b);
                    default: t = 1'b0;
                endcase
            end
            default: begin
                r = '0;
                t = 1'b0;
            end
        endcase
        return {t, r};
    endfunction

    state_t          state;
    logic [XLEN-1:0] result_p1;
    logic            bt_p1;
    logic            vld_p1;
    logic            busy_p1;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic [SHW:0]    cnt;

    logic            accept;
    logic            is_mul;
    logic [XLEN:0]   calc;

    // in_ready is masked by reset so nothing is accepted while it is held
    assign bus.in_ready = reset & ((state == IDLE) | ((state == OUT) & bus.out_ready));
    assign accept       = bus.in_valid & bus.in_ready;
    assign is_mul       = (MUL_EN != 0) && (bus.alu_sel == 2'b00) && (bus.alu_control == 4'd10);
    assign calc         = alu_eval(bus.op_a, bus.op_b, bus.imm, bus.alu_sel, bus.alu_control);

    assign bus.out_valid  = vld_p1;
    assign bus.alu_result = result_p1;
    assign bus.bt         = bt_p1;
    assign bus.busy       = busy_p1;
    assign bus.zero_flag  = (result_p1 == '0);

    // ---- stage p1: result registers, control FSM, multiplier engine ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            result_p1 <= '0;
            bt_p1     <= 1'b0;
            vld_p1    <= 1'b0;
            busy_p1   <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE, OUT: begin
                    if (accept) begin
                        if (is_mul) begin
                            mcand   <= bus.op_a;
                            mplier  <= bus.op_b;
                            acc     <= '0;
                            cnt     <= '0;
                            busy_p1 <= 1'b1;
                            vld_p1  <= 1'b0;
                            state   <= MUL_RUN;
                        end else begin
                            result_p1 <= calc[XLEN-1:0];
                            bt_p1     <= calc[XLEN];
                            vld_p1    <= 1'b1;
                            state     <= OUT;
                        end
                    end else if ((state == OUT) && bus.out_ready) begin
                        vld_p1 <= 1'b0;
                        state  <= IDLE;
                    end
                end
                MUL_RUN: begin
                    if (cnt == MUL_LAST) begin
                        result_p1 <= acc;
                        bt_p1     <= 1'b0;
                        busy_p1   <= 1'b0;
                        vld_p1    <= 1'b1;
                        state     <= OUT;
                    end else begin
                        // Only the low XLEN product bits are kept, so the
                        // multiplicand may simply shift out at the top
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: table-driven bench for alu_pipe (XLEN=32, MUL_EN=1).
//   A vector table covers the single-cycle ops back to back; hand-written
//   sequences cover reset, backpressure, MUL latency and reset mid-MUL.
module tb_alu_pipe;

    localparam int XLEN = 32;

    typedef struct {
        logic [1:0]      sel;
        logic [3:0]      ctl;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] res;
        logic            bt;
    } vec_t;

    localparam int NV = 24;

    logic clk;
    logic reset;
    int   nvec;
    int   errs;
    vec_t vecs[NV];

    alu_pipe_if #(.XLEN(XLEN)) bus ();

    alu_pipe #(.XLEN(XLEN), .MUL_EN(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " in_ready"},  {31'b0, bus.in_ready},  32'd0);
        chk({tag, " out_valid"}, {31'b0, bus.out_valid}, 32'd0);
        chk({tag, " busy"},      {31'b0, bus.busy},      32'd0);
        chk({tag, " bt"},        {31'b0, bus.bt},        32'd0);
        chk({tag, " zero_flag"}, {31'b0, bus.zero_flag}, 32'd1);
        chk({tag, " alu_result"}, bus.alu_result,        32'd0);
    endtask

    task automatic drive(input logic [1:0] sel, input logic [3:0] ctl,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] imm_v);
        bus.in_valid    = 1'b1;
        bus.alu_sel     = sel;
        bus.alu_control = ctl;
        bus.op_a        = a;
        bus.op_b        = b;
        bus.imm         = imm_v;
    endtask

    // Accepts a MUL on the next edge, then waits (bounded) for the result,
    // checking busy/in_ready while it runs and the exact latency.
    task automatic run_mul(input string tag, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp);
        int lat;
        int bad;
        drive(2'b00, 4'd10, a, b, 32'h0);
        bus.out_ready = 1'b1;
        step();
        chk({tag, " busy after accept"},      {31'b0, bus.busy},      32'd1);
        chk({tag, " out_valid after accept"}, {31'b0, bus.out_valid}, 32'd0);
        // Offered garbage must not disturb the running multiply
        drive(2'b00, 4'd0, 32'h1234_5678, 32'h0BAD_F00D, 32'h0);
        lat = 0;
        bad = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 33) bus.in_valid = 1'b0;
            step();
            if (bus.out_valid) begin
                lat = c;
                break;
            end
            if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) bad++;
            if (c == 32) bus.in_valid = 1'b0;
        end
        chk({tag, " latency"},        lat,                  32'd33);
        chk({tag, " busy/in_ready"},  bad,                  32'd0);
        chk({tag, " result"},         bus.alu_result,       exp);
        chk({tag, " bt"},             {31'b0, bus.bt},      32'd0);
        chk({tag, " busy at done"},   {31'b0, bus.busy},    32'd0);
    endtask

    initial begin
        nvec = 0;
        errs = 0;

        //         sel    ctl    a             b             imm           result        bt
        vecs[0]  = '{2'b00, 4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h0,        32'h80000000, 1'b0};
        vecs[1]  = '{2'b00, 4'd1,  32'h00000005, 32'h00000005, 32'h0,        32'h00000000, 1'b0};
        vecs[2]  = '{2'b00, 4'd2,  32'hF0F00000, 32'h00000F0F, 32'h0,        32'hF0F00F0F, 1'b0};
        vecs[3]  = '{2'b00, 4'd3,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0,        32'h0F000F00, 1'b0};
        vecs[4]  = '{2'b00, 4'd4,  32'hAAAA5555, 32'hFFFF0000, 32'h0,        32'h55555555, 1'b0};
        vecs[5]  = '{2'b00, 4'd5,  32'h00000001, 32'h00000021, 32'h0,        32'h00000002, 1'b0};
        vecs[6]  = '{2'b00, 4'd6,  32'h80000000, 32'h0000001F, 32'h0,        32'h00000001, 1'b0};
        vecs[7]  = '{2'b00, 4'd7,  32'h80000000, 32'h00000024, 32'h0,        32'hF8000000, 1'b0};
        vecs[8]  = '{2'b00, 4'd8,  32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h00000001, 1'b0};
        vecs[9]  = '{2'b00, 4'd9,  32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h00000000, 1'b0};
        vecs[10] = '{2'b01, 4'd0,  32'h0000000A, 32'h0000DEAD, 32'hFFFFFFFF, 32'h00000009, 1'b0};
        vecs[11] = '{2'b01, 4'd1,  32'h00000005, 32'h00000001, 32'h00000007, 32'hFFFFFFFE, 1'b0};
        vecs[12] = '{2'b01, 4'd10, 32'h00000003, 32'h00000009, 32'h00000004, 32'h00000000, 1'b0};
        vecs[13] = '{2'b00, 4'd12, 32'h12345678, 32'h11111111, 32'h0,        32'h00000000, 1'b0};
        vecs[14] = '{2'b10, 4'd2,  32'hFFFFFFFE, 32'h00000002, 32'h0,        32'h00000000, 1'b1};
        vecs[15] = '{2'b10, 4'd4,  32'hFFFFFFFE, 32'h00000002, 32'h0,        32'h00000000, 1'b0};
        vecs[16] = '{2'b10, 4'd5,  32'hFFFFFFFE, 32'h00000002, 32'h0,        32'h00000000, 1'b1};
        vecs[17] = '{2'b10, 4'd0,  32'h00000007, 32'h00000007, 32'h0,        32'h00000000, 1'b1};
        vecs[18] = '{2'b10, 4'd1,  32'h00000007, 32'h00000007, 32'h0,        32'h00000000, 1'b0};
        vecs[19] = '{2'b10, 4'd3,  32'hFFFFFFFE, 32'h00000002, 32'h0,        32'h00000000, 1'b0};
        vecs[20] = '{2'b10, 4'd9,  32'h00000007, 32'h00000007, 32'h0,        32'h00000000, 1'b0};
        vecs[21] = '{2'b11, 4'd0,  32'h00000007, 32'h00000007, 32'h0,        32'h00000000, 1'b0};
        vecs[22] = '{2'b01, 4'd5,  32'h00000003, 32'hFFFFFFFF, 32'h00000004, 32'h00000030, 1'b0};
        vecs[23] = '{2'b00, 4'd7,  32'h40000000, 32'h00000022, 32'h0,        32'h10000000, 1'b0};

        // Reset held with an op on offer: nothing accepted, outputs at reset values
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        drive(2'b00, 4'd0, 32'h1, 32'h1, 32'h0);
        #1;
        chk_reset_state("reset");
        step();
        step();
        chk_reset_state("reset held");
        reset = 1'b1;
        #1;
        chk("in_ready after release", {31'b0, bus.in_ready}, 32'd1);

        // Table, back to back with out_ready=1: one result per cycle
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].sel, vecs[i].ctl, vecs[i].a, vecs[i].b, vecs[i].imm);
            step();
            chk($sformatf("v%0d out_valid", i), {31'b0, bus.out_valid}, 32'd1);
            chk($sformatf("v%0d result", i),    bus.alu_result, vecs[i].res);
            chk($sformatf("v%0d bt", i),        {31'b0, bus.bt}, {31'b0, vecs[i].bt});
            chk($sformatf("v%0d zero_flag", i), {31'b0, bus.zero_flag},
                {31'b0, (vecs[i].res == 32'd0)});
        end
        bus.in_valid = 1'b0;
        step();
        chk("drain out_valid", {31'b0, bus.out_valid}, 32'd0);

        // Backpressure: result held while out_ready=0, then no bubble
        bus.out_ready = 1'b0;
        drive(2'b00, 4'd0, 32'd2, 32'd3, 32'h0);
        step();
        chk("bp first result", bus.alu_result, 32'd5);
        drive(2'b00, 4'd0, 32'd100, 32'd1, 32'h0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("bp hold%0d result", c),    bus.alu_result, 32'd5);
            chk($sformatf("bp hold%0d out_valid", c), {31'b0, bus.out_valid}, 32'd1);
            chk($sformatf("bp hold%0d in_ready", c),  {31'b0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp in_ready on release", {31'b0, bus.in_ready}, 32'd1);
        step();
        chk("bp next result",    bus.alu_result, 32'd101);
        chk("bp next out_valid", {31'b0, bus.out_valid}, 32'd1);

        // MUL accepted from OUT (previous result consumed on the same edge)
        run_mul("mul1", 32'h0001_0003, 32'h0000_0005, 32'h0005_000F);
        run_mul("mul2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        step();
        chk("mul drain out_valid", {31'b0, bus.out_valid}, 32'd0);

        // Reset asserted 10 cycles into a MUL aborts it
        drive(2'b00, 4'd10, 32'h0000_0007, 32'h0000_0009, 32'h0);
        step();
        bus.in_valid = 1'b0;
        for (int c = 0; c < 10; c++) step();
        reset = 1'b0;
        #1;
        chk_reset_state("mid-mul reset");
        step();
        step();
        reset = 1'b1;
        drive(2'b00, 4'd0, 32'd2, 32'd3, 32'h0);
        step();
        chk("post-reset add result",    bus.alu_result, 32'd5);
        chk("post-reset add out_valid", {31'b0, bus.out_valid}, 32'd1);
        bus.in_valid = 1'b0;
        begin
            int stale;
            stale = 0;
            for (int c = 0; c < 40; c++) begin
                step();
                if (bus.out_valid !== 1'b0 || bus.alu_result !== 32'd5 || bus.busy !== 1'b0) stale++;
            end
            chk("no stale mul result", stale, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
